// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Frame settings are captured on accept so input changes never disturb a frame in flight.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TX_CLK,
  input  logic                  TX_RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic [2:0]            state_dbg
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [4:0]            edge_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            presc_q;

  logic accept;
  logic bit_wrap;
  logic last_bit;
  logic active;
  logic parity_bit;

  // Handshake: DATA_VALID is a request with no ready; it is taken on a rising
  // edge only while the block is in IDLE (Busy=0), otherwise it is dropped.
  assign accept     = (state_q == S_IDLE) && DATA_VALID;
  assign bit_wrap   = ({1'b0, edge_cnt_q} == (presc_q - 6'd1));
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign active     = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
  assign parity_bit = (^data_q) ^ par_typ_q;

  always_ff @(posedge TX_CLK or negedge TX_RST) begin
    if (!TX_RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (DATA_VALID) state_d = S_START;
      S_START:  if (bit_wrap) state_d = S_DATA;
      S_DATA:   if (bit_wrap && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_wrap) state_d = S_STOP;
      S_STOP:   if (bit_wrap) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Edge counter spans one bit period; bit counter advances on each data-bit wrap.
  always_ff @(posedge TX_CLK or negedge TX_RST) begin
    if (!TX_RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      if (active && !bit_wrap) begin
        edge_cnt_q <= edge_cnt_q + 5'd1;
      end else begin
        edge_cnt_q <= '0;
      end
      if (state_q != S_DATA) begin
        bit_cnt_q <= '0;
      end else if (bit_wrap) begin
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge TX_CLK or negedge TX_RST) begin
    if (!TX_RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      presc_q   <= Prescale;
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = data_q[bit_cnt_q];
      S_PARITY: TX_OUT = parity_bit;
      default:  TX_OUT = 1'b1;
    endcase
  end

  assign Busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
